// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ADD/SUB/PASSB, iterative shift-add MUL.
// Define MUL_EARLY_EXIT_EN to end MUL once the remaining multiplier is zero.
module seq_alu #(
  parameter int WORD_SIZE = 24,
  parameter int CNT_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  output logic [WORD_SIZE-1:0] alu_out,
  output logic                 done,
  output logic                 busy,
  output logic                 zero_flag,
  output logic                 carry_flag
);

  localparam int PW = 2 * WORD_SIZE;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_SIZE - 1);

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        mcand_q, mcand_d;
  logic [WORD_SIZE-1:0] mplier_q, mplier_d;
  logic [PW-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [WORD_SIZE-1:0] res_q, res_d;
  logic                 done_q, done_d;
  logic                 zero_q, zero_d;
  logic                 carry_q, carry_d;

  logic [WORD_SIZE:0]   sum;
  logic [WORD_SIZE:0]   diff;
  logic [PW-1:0]        acc_step;
  logic                 mul_last;
  logic [WORD_SIZE-1:0] res_n;
  logic                 cy_n;

  assign sum      = {1'b0, a} + {1'b0, b};
  // Top bit of the widened difference is the unsigned borrow (a < b).
  assign diff     = {1'b0, a} - {1'b0, b};
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef MUL_EARLY_EXIT_EN
  assign mul_last = (count_q == LAST) ||
                    (mplier_q[WORD_SIZE-1:1] == '0);
`else
  assign mul_last = (count_q == LAST);
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    res_d    = res_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    res_n    = '0;
    cy_n     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (op)
            2'b00: begin
              res_n  = sum[WORD_SIZE-1:0];
              cy_n   = sum[WORD_SIZE];
              done_d = 1'b1;
            end
            2'b01: begin
              res_n  = diff[WORD_SIZE-1:0];
              cy_n   = diff[WORD_SIZE];
              done_d = 1'b1;
            end
            2'b10: begin
              mcand_d  = {{WORD_SIZE{1'b0}}, b};
              mplier_d = a;
              acc_d    = '0;
              count_d  = '0;
              state_d  = S_MUL;
            end
            default: begin
              res_n  = b;
              done_d = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (mul_last) begin
          res_n   = acc_step[WORD_SIZE-1:0];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (done_d) begin
      res_d   = res_n;
      zero_d  = (res_n == '0);
      carry_d = cy_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      res_q    <= '0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      res_q    <= res_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end

  assign alu_out    = res_q;
  assign done       = done_q;
  assign busy       = (state_q == S_MUL);
  assign zero_flag  = zero_q;
  assign carry_flag = carry_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: vector table plus MUL/reset sequences.
// Results are checked through a scoreboard popped on every done pulse.
module tb_seq_alu;
  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] alu_out;
  logic         done;
  logic         busy;
  logic         zero_flag;
  logic         carry_flag;

  seq_alu #(.WORD_SIZE(W), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .alu_out    (alu_out),
    .done       (done),
    .busy       (busy),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         c;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         c;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] r, input logic c);
    exp_t e;
    e.res = r;
    e.z   = (r == '0);
    e.c   = c;
    sb.push_back(e);
  endtask

  function automatic int exp_lat(input logic [W-1:0] m);
`ifdef MUL_EARLY_EXIT_EN
    int n = 0;
    for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
    return (n == 0) ? 1 : n;
`else
    return W;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst && done) begin
      exp_t e;
      tests++;
      if (busy) begin
        fails++;
        $display("FAIL done_busy: done and busy both high");
      end else if (sb.size() == 0) begin
        fails++;
        $display("FAIL spurious_done: got done=1 expected none");
      end else begin
        e = sb.pop_front();
        if (alu_out !== e.res || zero_flag !== e.z ||
            carry_flag !== e.c) begin
          fails++;
          $display("FAIL result: got %h z%b c%b expected %h z%b c%b",
                   alu_out, zero_flag, carry_flag, e.res, e.z, e.c);
        end
      end
    end
  end

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_alu_out"}, 32'(alu_out), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_zero"}, 32'(zero_flag), 32'h0);
    chk({tag, "_carry"}, 32'(carry_flag), 32'h0);
  endtask

  task automatic run_mul(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input bit noise);
    logic [2*W-1:0] p;
    logic [W-1:0]   hold;
    int             lat, k, bc;
    bit             changed;
    p = {{W{1'b0}}, ma} * {{W{1'b0}}, mb};
    push_exp(p[W-1:0], 1'b0);
    lat = exp_lat(ma);
    @(posedge clk); #1;
    start = 1'b1; op = 2'b10; a = ma; b = mb;
    @(posedge clk); #1;
    start = 1'b0;
    hold = alu_out;
    k = 1; bc = 0; changed = 0;
    while (k <= 60) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) break;
      if (alu_out !== hold) changed = 1;
      if (noise) begin
        start = (k % 3 == 1);
        op = 2'b00;
        a = W'($urandom);
        b = W'($urandom);
      end
      k++;
    end
    start = 1'b0;
    chk("mul_latency", 32'(k - 1), 32'(lat));
    chk("mul_busy_cycles", 32'(bc), 32'(lat));
    chk("mul_hold", 32'(changed), 32'h0);
  endtask

  vec_t tv[16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W:0] t;
    tv[0] = '{2'b00, 24'hFFFFFF, 24'h000001, 24'h000000, 1'b1, 1'b1};
    tv[1] = '{2'b01, 24'h000005, 24'h000007, 24'hFFFFFE, 1'b0, 1'b1};
    tv[2] = '{2'b11, 24'h000000, 24'h123456, 24'h123456, 1'b0, 1'b0};
    tv[3] = '{2'b00, 24'h000100, 24'h000200, 24'h000300, 1'b0, 1'b0};
    tv[4] = '{2'b01, 24'h000007, 24'h000007, 24'h000000, 1'b1, 1'b0};
    tv[5] = '{2'b11, 24'hABCDEF, 24'h000000, 24'h000000, 1'b1, 1'b0};
    tv[6] = '{2'b00, 24'h800000, 24'h800000, 24'h000000, 1'b1, 1'b1};
    tv[7] = '{2'b01, 24'h000000, 24'h000001, 24'hFFFFFF, 1'b0, 1'b1};
    for (int i = 8; i < 16; i++) begin
      tv[i].op = (i % 2 == 0) ? 2'b00 : 2'b01;
      tv[i].a  = W'($urandom);
      tv[i].b  = W'($urandom);
      if (tv[i].op == 2'b00) t = {1'b0, tv[i].a} + {1'b0, tv[i].b};
      else t = {1'b0, tv[i].a} - {1'b0, tv[i].b};
      tv[i].res = t[W-1:0];
      tv[i].z   = (t[W-1:0] == '0);
      tv[i].c   = (tv[i].op == 2'b00) ? t[W] : (tv[i].a < tv[i].b);
    end

    repeat (2) @(negedge clk);
    chk_zero_outs("por");
    rst = 1'b1;

    // Back-to-back single-cycle ops with start held high.
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      start = 1'b1; op = tv[i].op; a = tv[i].a; b = tv[i].b;
      push_exp(tv[i].res, tv[i].c);
      @(posedge clk); #1;
      chk("busy_alu", 32'(busy), 32'h0);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("table_drained", 32'(sb.size()), 32'h0);
    chk("flags_hold", {7'(0), zero_flag, carry_flag, alu_out},
        {7'(0), tv[15].z, tv[15].c, tv[15].res});

    run_mul(24'd1000, 24'd3000, 1'b1);
    run_mul(24'h001000, 24'h001000, 1'b0);
    run_mul(24'd3, 24'h000100, 1'b0);
    run_mul(24'd0, 24'h000055, 1'b0);
    run_mul(24'd1, 24'hFFFFFF, 1'b1);
    run_mul(24'hFFFFFF, 24'hFFFFFF, 1'b0);

    // Start accepted in the IDLE cycle right after MUL completion.
    run_mul(24'd2, 24'd3, 1'b0);
    start = 1'b1; op = 2'b00; a = 24'd1; b = 24'd2;
    push_exp(24'd3, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_mul_add", 32'(sb.size()), 32'h0);

    // Reset ten cycles into a MUL aborts it silently.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b10; a = 24'd7; b = 24'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_zero_outs("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("no_done_after_abort", 32'(sb.size()), 32'h0);
    run_mul(24'd7, 24'd9, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
